// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// axi_lite_if: 32-bit AXI-lite bundle shared by the IFU, LSU and xbar ports.
//   master modport: drives aw/w/ar payload and valids, bready/rready.
//   slave  modport: drives awready/wready/arready, b and r payload and valids.
interface axi_lite_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arsize, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arsize, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// ysyx_24110015_axi_arbiter: two-to-one AXI-lite arbiter (IFU read-only, LSU
// read/write) onto one memory-side master port. One whole transaction
// (address, data, response) is granted at a time.
//   clk, rst    : clock, synchronous active-high reset
//   ifu         : IFU slave port (ar/r only; aw/w/b outputs tied to 0)
//   lsu         : LSU slave port (all channels)
//   mem         : master port toward the xbar
//   grant       : current owner 0 IDLE, 1 IFU_RD, 2 LSU_RD, 3 LSU_WR
//   starve_cnt  : LSU grants taken while the IFU was waiting
module ysyx_24110015_axi_arbiter #(
   parameter int STARVE_MAX = 4,
   localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1
) (
   input  logic           clk,
   input  logic           rst,
   axi_lite_if.slave      ifu,
   axi_lite_if.slave      lsu,
   axi_lite_if.master     mem,
   output logic [1:0]     grant,
   output logic [CW-1:0]  starve_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFU_RD = 2'd1,
      LSU_RD = 2'd2,
      LSU_WR = 2'd3
   } grant_e;

   localparam logic [CW-1:0] STARVE_SAT = CW'(STARVE_MAX);

   grant_e        grant_q, grant_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          rd_done, wr_done, starve_hit;

   // The IFU never writes; fold its write-side inputs so they are visibly consumed.
   logic unused_ifu_wr;
   assign unused_ifu_wr = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb, ifu.wvalid, ifu.bready};

   // Completion is judged on the forwarded rready/bready, i.e. the granted master's.
   assign rd_done    = mem.rvalid & ((grant_q == IFU_RD) ? ifu.rready : lsu.rready);
   assign wr_done    = mem.bvalid & lsu.bready;
   assign starve_hit = (STARVE_MAX != 0) && (starve_cnt_q == STARVE_SAT) && ifu.arvalid;

   always_comb begin
      grant_d      = grant_q;
      starve_cnt_d = starve_cnt_q;
      case (grant_q)
         IDLE: begin
            if (starve_hit)        grant_d = IFU_RD;
            else if (lsu.awvalid)  grant_d = LSU_WR;
            else if (lsu.arvalid)  grant_d = LSU_RD;
            else if (ifu.arvalid)  grant_d = IFU_RD;
            // Count only LSU wins that actually made a waiting IFU wait longer.
            if (grant_d == IFU_RD)
               starve_cnt_d = '0;
            else if ((grant_d != IDLE) && ifu.arvalid && (starve_cnt_q != STARVE_SAT))
               starve_cnt_d = starve_cnt_q + 1'b1;
         end
         IFU_RD, LSU_RD: if (rd_done) grant_d = IDLE;
         LSU_WR:         if (wr_done) grant_d = IDLE;
         default:        grant_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q      <= IDLE;
         starve_cnt_q <= '0;
      end else begin
         grant_q      <= grant_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign grant      = grant_q;
   assign starve_cnt = starve_cnt_q;

   // Channel steering is purely combinational from the registered grant, so
   // every forwarded beat has zero added latency and IDLE blocks everything.
   always_comb begin
      mem.awaddr  = '0;  mem.awvalid = 1'b0;
      mem.wdata   = '0;  mem.wstrb   = '0;  mem.wvalid = 1'b0;
      mem.bready  = 1'b0;
      mem.araddr  = '0;  mem.arsize  = '0;  mem.arvalid = 1'b0;
      mem.rready  = 1'b0;

      ifu.awready = 1'b0; ifu.wready = 1'b0;
      ifu.bresp   = '0;   ifu.bvalid = 1'b0;
      ifu.arready = 1'b0;
      ifu.rdata   = '0;   ifu.rresp  = '0;  ifu.rvalid = 1'b0;

      lsu.awready = 1'b0; lsu.wready = 1'b0;
      lsu.bresp   = '0;   lsu.bvalid = 1'b0;
      lsu.arready = 1'b0;
      lsu.rdata   = '0;   lsu.rresp  = '0;  lsu.rvalid = 1'b0;

      case (grant_q)
         IFU_RD: begin
            mem.araddr  = ifu.araddr;
            mem.arsize  = ifu.arsize;
            mem.arvalid = ifu.arvalid;
            ifu.arready = mem.arready;
            ifu.rdata   = mem.rdata;
            ifu.rresp   = mem.rresp;
            ifu.rvalid  = mem.rvalid;
            mem.rready  = ifu.rready;
         end
         LSU_RD: begin
            mem.araddr  = lsu.araddr;
            mem.arsize  = lsu.arsize;
            mem.arvalid = lsu.arvalid;
            lsu.arready = mem.arready;
            lsu.rdata   = mem.rdata;
            lsu.rresp   = mem.rresp;
            lsu.rvalid  = mem.rvalid;
            mem.rready  = lsu.rready;
         end
         LSU_WR: begin
            // aw and w pass independently; W may trail AW by any number of cycles.
            mem.awaddr  = lsu.awaddr;
            mem.awvalid = lsu.awvalid;
            lsu.awready = mem.awready;
            mem.wdata   = lsu.wdata;
            mem.wstrb   = lsu.wstrb;
            mem.wvalid  = lsu.wvalid;
            lsu.wready  = mem.wready;
            lsu.bresp   = mem.bresp;
            lsu.bvalid  = mem.bvalid;
            mem.bready  = lsu.bready;
         end
         default: ;
      endcase
   end

endmodule
